// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: drives an external ALU for 32
// shift-add (multiply) or restoring-subtract (divide) iterations.
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif

module mdu_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_fn_o,
  input  logic [31:0] alu_r_i,
  input  logic        alu_cf_i
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  fn_q, fn_d;
  // hi/lo hold the product for multiply and R/Q for divide
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dv_q, dv_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  logic        is_div, a_signed, b_signed, a_neg, b_neg, sub_ok, div_ovf;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_raw, prod_s;

  assign is_div   = fn_q[2];
  assign a_signed = (fn_q == 3'b001) || (fn_q == 3'b010) || (fn_q == 3'b100) || (fn_q == 3'b110);
  assign b_signed = (fn_q == 3'b001) || (fn_q == 3'b100) || (fn_q == 3'b110);
  assign a_neg    = a_signed && lo_q[31];
  assign b_neg    = b_signed && dv_q[31];
  assign mag_a    = a_neg ? (32'd0 - lo_q) : lo_q;
  assign mag_b    = b_neg ? (32'd0 - dv_q) : dv_q;
  // signed overflow case: only DIV/REM (fn[0]=0) with the most negative dividend over -1
  assign div_ovf  = is_div && !fn_q[0] && (lo_q == 32'h8000_0000) && (dv_q == 32'hFFFF_FFFF);
  // shifted-out R[31] means the 33-bit partial remainder certainly exceeds D
  assign sub_ok   = hi_q[31] || alu_cf_i;
  assign prod_raw = {hi_q, lo_q};
  assign prod_s   = neg_res_q ? (64'd0 - prod_raw) : prod_raw;

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_fn_o = `ALU_ADD;
    if (state_q == S_CALC) begin
      alu_b_o = dv_q;
      if (is_div) begin
        alu_a_o  = {hi_q[30:0], lo_q[31]};
        alu_fn_o = `ALU_SUB;
      end else begin
        alu_a_o = hi_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dv_d      = dv_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          fn_d    = funct3_i;
          hi_d    = '0;
          lo_d    = rs1_i;
          dv_d    = rs2_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        cnt_d     = '0;
        if (is_div && (dv_q == 32'd0)) begin
          result_d = fn_q[1] ? lo_q : 32'hFFFF_FFFF;
          state_d  = S_DONE;
        end else if (div_ovf) begin
          result_d = fn_q[1] ? 32'd0 : 32'h8000_0000;
          state_d  = S_DONE;
        end else begin
          hi_d    = '0;
          lo_d    = mag_a;
          dv_d    = mag_b;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div) begin
          hi_d = sub_ok ? alu_r_i : alu_a_o;
          lo_d = {lo_q[30:0], sub_ok};
        end else if (lo_q[0]) begin
          {hi_d, lo_d} = {alu_cf_i, alu_r_i, lo_q[31:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div)      result_d = (fn_q == 3'b000) ? prod_s[31:0] : prod_s[63:32];
        else if (!fn_q[1]) result_d = neg_res_q ? (32'd0 - lo_q) : lo_q;
        else               result_d = neg_rem_q ? (32'd0 - hi_q) : hi_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      fn_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dv_q      <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dv_q      <= dv_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: behavioural ALU, directed vector table, corner
// sequences and randomized ops against an arithmetic reference model.
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif

module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        rst_ni, start_i, alu_cf_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i, alu_r_i;
  logic        busy_o, done_o;
  logic [31:0] result_o, alu_a_o, alu_b_o;
  logic [3:0]  alu_fn_o;
  logic [32:0] alu_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_fn_o(alu_fn_o), .alu_r_i(alu_r_i), .alu_cf_i(alu_cf_i)
  );

  always_comb begin
    if (alu_fn_o == `ALU_SUB) begin
      alu_t    = {1'b0, alu_a_o} - {1'b0, alu_b_o};
      alu_cf_i = ~alu_t[32];
    end else begin
      alu_t    = {1'b0, alu_a_o} + {1'b0, alu_b_o};
      alu_cf_i = alu_t[32];
    end
    alu_r_i = alu_t[31:0];
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat, subs;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    sa = a; sb = b;
    case (f)
      3'b000: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
      3'b001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'b010: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      3'b011: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issues one op (inputs driven #1 after an edge), returns result, the
  // number of edges from accept to done, and the count of SUB cycles seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, output logic [31:0] res, output int lat, output int subs);
    int n;
    start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; funct3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
    n = 0; subs = 0; lat = -1; res = 'x;
    while (n < 60) begin
      if (done_o) begin lat = n; res = result_o; break; end
      if (alu_fn_o == `ALU_SUB) subs++;
      start_i = (n == pulse_at);
      @(posedge clk); #1; n++;
    end
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t        vecs[14];
  logic [31:0] res, a, b;
  logic [2:0]  f;
  int          lat, subs, dcnt, n;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; funct3_i = '0; rs1_i = '0; rs2_i = '0;
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0};
    vecs[1]  = '{3'b011, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 34, 0};
    vecs[2]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0};
    vecs[4]  = '{3'b101, 32'd100,        32'd7,         32'd14,        34, 32};
    vecs[5]  = '{3'b111, 32'd100,        32'd7,         32'd2,         34, 32};
    vecs[6]  = '{3'b100, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 34, 32};
    vecs[7]  = '{3'b110, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 34, 32};
    vecs[8]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0};
    vecs[9]  = '{3'b111, 32'd5,          32'd0,         32'd5,         1,  0};
    vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0};
    vecs[11] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0};
    vecs[12] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0};
    vecs[13] = '{3'b111, 32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE, 34, 32};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_alu_a", alu_a_o, 32'd0);
    chk("rst_alu_fn", 32'(alu_fn_o), 32'(`ALU_ADD));
    rst_ni = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, -1, res, lat, subs);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_subcycles", i), 32'(subs), 32'(vecs[i].subs));
    end

    // stray start pulse mid-operation must be ignored
    run_op(3'b101, 32'd100, 32'd7, 10, res, lat, subs);
    chk("pulse_result", res, 32'd14);
    chk("pulse_latency", 32'(lat), 32'd34);

    // start held high: the next accept only happens once IDLE is re-entered
    start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd5;
    @(posedge clk); #1;
    n = 0;
    while (n < 60 && !done_o) begin @(posedge clk); #1; n++; end
    chk("hold_latency", 32'(n), 32'd34);
    chk("hold_result", result_o, 32'd15);
    @(posedge clk); #1;
    chk("hold_idle_gap", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    chk("hold_reaccept", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    n = 0;
    while (n < 60 && !done_o) begin @(posedge clk); #1; n++; end
    chk("hold_second_result", result_o, 32'd15);
    @(posedge clk); #1;

    // asynchronous reset after 10 CALC iterations
    start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'h0001_2345; rs2_i = 32'h0000_0777;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_alu_b", alu_b_o, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    run_op(3'b000, 32'd3, 32'd4, -1, res, lat, subs);
    chk("postrst_result", res, 32'd12);
    chk("postrst_latency", 32'(lat), 32'd34);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 300) - 150; b = $urandom_range(0, 20) - 10; end
        2: begin a = $urandom; b = 32'd0; end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
      endcase
      run_op(f, a, b, -1, res, lat, subs);
      chk($sformatf("rnd%0d_f%0d_%h_%h_result", i, f, a, b), res, ref_op(f, a, b));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), is_special(f, a, b) ? 32'd1 : 32'd34);
      chk($sformatf("rnd%0d_subcycles", i), 32'(subs),
          (f[2] && !is_special(f, a, b)) ? 32'd32 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
